// File: rtl/mul_pkg.sv
// Shared definitions for the sequential RV32M multiplier: widths, op codes,
// FSM states and the two's-complement magnitude helper.
package mul_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned PRODW = 2 * XLEN;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } state_e;

  // Absolute value of a signed operand; -2^31 maps to the unsigned 2^31.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return s ? (~v) + XLEN'(1) : v;
  endfunction

endpackage

// File: rtl/add32.sv
// 32-bit adder with carry-in and carry-out; the accumulation adder of the multiplier.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = 33'(a) + 33'(b) + 33'(cin);

endmodule

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Fixed 33-cycle latency from acceptance to result, one operation in flight.
module alu_mul_seq
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  state_e             state, state_next;
  logic [1:0]         op_q;
  logic               neg;
  logic [XLEN-1:0]    mcand;
  logic [XLEN-1:0]    mplier;
  logic [PRODW-1:0]   prod;
  logic [CNT_W-1:0]   count;

  logic               sa, sb;
  logic [XLEN-1:0]    addend, sum;
  logic               cout;
  logic [PRODW-1:0]   prod_fin;
  logic [XLEN-1:0]    result_d;
  logic               in_ready_d, out_valid_d, busy_d;

  // Operand sign flags decoded from the incoming op.
  assign sa = ((op == OP_MULH) || (op == OP_MULHSU)) && A[XLEN-1];
  assign sb = (op == OP_MULH) && B[XLEN-1];

  assign addend = mplier[0] ? mcand : '0;

  add32 u_add (
    .a    (prod[PRODW-1:XLEN]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign prod_fin = neg ? (~prod) + PRODW'(1) : prod;
  assign result_d = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[PRODW-1:XLEN];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; kill aborts any non-idle state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = CALC;
      CALC: begin
        if (kill)                              state_next = IDLE;
        else if (count == CNT_W'(ITERS - 1))   state_next = SIGN;
      end
      SIGN: state_next = kill ? IDLE : DONE;
      DONE: if (kill || out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/status values for the coming cycle, registered below.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    if (state_next == IDLE) begin
      in_ready_d = 1'b1;
      busy_d     = 1'b0;
    end
    if (state_next == DONE) out_valid_d = 1'b1;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      op_q      <= '0;
      neg       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      count     <= '0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            neg    <= sa ^ sb;
            mcand  <= mag(A, sa);
            mplier <= mag(B, sb);
            prod   <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          if (!kill) begin
            prod   <= {cout, sum, prod[XLEN-1:1]};
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
          end
        end
        SIGN: begin
          if (!kill) begin
            prod   <= prod_fin;
            result <= result_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq with hand-computed products.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int LAT = 34;  // negedges from request drive until out_valid seen

  alu_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (a_in),
    .B         (b_in),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; lat counts negedges.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    in_valid = 1'b0; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'h0)
      $display("FAIL reset: rdy/vld/busy=%b result=%h, want 100 / 00000000",
               {in_ready, out_valid, busy}, result);
    else n_pass++;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    int lat;
    run_op(2'b00, 32'd7, 32'hFFFFFFFD, lat);
    n_checks++;
    if (lat !== LAT) $display("FAIL mul_lat: got %0d want %0d", lat, LAT);
    else n_pass++;
    n_checks++;
    if (result !== 32'hFFFFFFEB) $display("FAIL mul_7x-3: got %h want FFFFFFEB", result);
    else n_pass++;
    accept();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL mul_return_idle: rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    else n_pass++;
  endtask

  task automatic test_ops();
    int lat;
    logic [1:0]  ops [6] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                             32'h80000000, 32'hFFFFFFFE};
    logic [31:0] bs  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                             32'h00000002, 32'h00000003};
    logic [31:0] exp [6] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      n_checks++;
      if (lat !== LAT || result !== exp[i])
        $display("FAIL op_vec%0d: lat=%0d result=%h, want lat=%0d result=%h",
                 i, lat, result, LAT, exp[i]);
      else n_pass++;
      accept();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic stable = 1'b1;
    run_op(2'b00, 32'd1234, 32'd1000, lat);
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || result !== 32'd1234000)
        stable = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!stable || out_valid !== 1'b1 || result !== 32'd1234000)
      $display("FAIL backpressure_hold: vld=%b rdy=%b result=%h, want 1 0 %h",
               out_valid, in_ready, result, 32'd1234000);
    else n_pass++;
    accept();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL backpressure_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    else n_pass++;
    run_op(2'b00, 32'h0, 32'h12345678, lat);
    n_checks++;
    if (lat !== LAT || result !== 32'h0)
      $display("FAIL zero_operand: lat=%0d result=%h, want %0d 00000000", lat, result, LAT);
    else n_pass++;
    accept();
  endtask

  task automatic test_kill();
    int lat;
    logic never = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; a_in = 32'd99; b_in = 32'd77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL kill_idle: rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) never = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!never) $display("FAIL kill_no_valid: out_valid rose after kill, want 0");
    else n_pass++;
    run_op(2'b00, 32'd3, 32'd4, lat);
    n_checks++;
    if (lat !== LAT || result !== 32'd12)
      $display("FAIL kill_then_mul: lat=%0d result=%h, want %0d 0000000c", lat, result, LAT);
    else n_pass++;
    accept();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; a_in = 32'd5; b_in = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'h0)
      $display("FAIL reset_calc: rdy/vld/busy=%b result=%h, want 100 00000000",
               {in_ready, out_valid, busy}, result);
    else n_pass++;
    run_op(2'b00, 32'd5, 32'd6, lat);
    n_checks++;
    if (result !== 32'd30) $display("FAIL mul_5x6: got %h want 0000001e", result);
    else n_pass++;
    // Reset while in DONE, with a request held high across the reset edge.
    rst_n = 1'b0; in_valid = 1'b1; op = 2'b00; a_in = 32'd2; b_in = 32'd2;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'h0)
      $display("FAIL reset_done: rdy/vld/busy=%b result=%h, want 100 00000000",
               {in_ready, out_valid, busy}, result);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL accept_after_reset: busy=%b rdy=%b want 1 0", busy, in_ready);
    else n_pass++;
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(2'b11, 32'h00010000, 32'h00010000, lat);
    n_checks++;
    if (lat !== LAT || result !== 32'h00000001)
      $display("FAIL b2b_first: lat=%0d result=%h, want %0d 00000001", lat, result, LAT);
    else n_pass++;
    accept();
    run_op(2'b00, 32'h00010001, 32'h0000FFFF, lat);
    n_checks++;
    if (lat !== LAT || result !== 32'hFFFFFFFF)
      $display("FAIL b2b_second: lat=%0d result=%h, want %0d ffffffff", lat, result, LAT);
    else n_pass++;
    accept();
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_ops();
    test_backpressure();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
